// File: rtl/hh_synapse.sv
// Spike-to-current synapse: rising-edge detect with refractory hold-off, weighted decaying accumulator.
// Optional SYN_INHIB_EN: weight bit 7 marks an inhibitory synapse (magnitude in bits 6:0).
module hh_synapse #(
    parameter int unsigned N_IN        = 4,
    parameter int unsigned DECAY_SHIFT = 3,
    parameter int unsigned REFRAC      = 4,
    parameter logic [7:0]  W_INIT      = 8'd16,
    localparam int unsigned AW         = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] spike_in,
    input  logic            enable,
    input  logic            w_we,
    input  logic [AW-1:0]   w_addr,
    input  logic [7:0]      w_data,
    output logic [7:0]      stim_current,
    output logic [15:0]     event_count,
    output logic            sat_flag
);

    localparam int unsigned RW     = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam int unsigned ACC_W  = 12;
    localparam int unsigned SUM_W  = 14;
    localparam int unsigned POP_W  = 4;

    logic [7:0]       weight [N_IN];
    logic [RW-1:0]    refr   [N_IN];
    logic [N_IN-1:0]  spk_q;
    logic [N_IN-1:0]  ev;
    logic [ACC_W-1:0] acc;
    logic [SUM_W-1:0] leak;
    logic [SUM_W-1:0] exc_sum;
    logic [SUM_W-1:0] acc_next;
    logic [POP_W-1:0] ev_pop;
`ifdef SYN_INHIB_EN
    logic [SUM_W-1:0] inh_sum;
`endif

    // Event detection, weight summation and leaky accumulator update
    always_comb begin
        ev      = '0;
        exc_sum = '0;
        ev_pop  = '0;
`ifdef SYN_INHIB_EN
        inh_sum = '0;
`endif
        for (int i = 0; i < int'(N_IN); i++) begin
            ev[i] = spike_in[i] & ~spk_q[i] & (refr[i] == '0) & enable;
            if (ev[i]) begin
                ev_pop = ev_pop + POP_W'(1);
`ifdef SYN_INHIB_EN
                if (weight[i][7]) begin
                    inh_sum = inh_sum + SUM_W'(weight[i][6:0]);
                end else begin
                    exc_sum = exc_sum + SUM_W'(weight[i][6:0]);
                end
`else
                exc_sum = exc_sum + SUM_W'(weight[i]);
`endif
            end
        end
        leak = SUM_W'(acc >> DECAY_SHIFT);
        // Minimum leak of one so small residues drain fully to zero
        if ((acc != '0) && (leak == '0)) begin
            leak = SUM_W'(1);
        end
        acc_next = SUM_W'(acc) - leak + exc_sum;
`ifdef SYN_INHIB_EN
        acc_next = (inh_sum > acc_next) ? '0 : (acc_next - inh_sum);
`endif
    end

    // State registers; weight writes land after this cycle's events use the old value
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spk_q        <= '0;
            acc          <= '0;
            stim_current <= '0;
            event_count  <= '0;
            sat_flag     <= 1'b0;
            for (int i = 0; i < int'(N_IN); i++) begin
                refr[i]   <= '0;
                weight[i] <= W_INIT;
            end
        end else begin
            spk_q <= spike_in;
            for (int i = 0; i < int'(N_IN); i++) begin
                if (ev[i]) begin
                    refr[i] <= RW'(REFRAC);
                end else if (refr[i] != '0) begin
                    refr[i] <= refr[i] - RW'(1);
                end
            end
            if (acc_next > SUM_W'(4095)) begin
                acc      <= '1;
                sat_flag <= 1'b1;
            end else begin
                acc <= acc_next[ACC_W-1:0];
            end
            stim_current <= (acc_next > SUM_W'(255)) ? 8'hFF : acc_next[7:0];
            event_count  <= event_count + 16'(ev_pop);
            if (w_we && (32'(w_addr) < N_IN)) begin
                weight[w_addr] <= w_data;
            end
        end
    end

endmodule

// File: tb/tb_hh_synapse.sv
// Scoreboard bench for hh_synapse: stimulus queues expected outputs per cycle, a monitor compares them.
// Second instance uses REFRAC=0 for the saturation scenario.
module tb_hh_synapse;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  spike_in;
    logic        enable;
    logic        w_we;
    logic [1:0]  w_addr;
    logic [7:0]  w_data;
    logic [7:0]  stim_a, stim_b;
    logic [15:0] count_a, count_b;
    logic        sat_a, sat_b;

    hh_synapse dut (
        .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .enable(enable),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .stim_current(stim_a), .event_count(count_a), .sat_flag(sat_a)
    );

    hh_synapse #(.REFRAC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .enable(enable),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .stim_current(stim_b), .event_count(count_b), .sat_flag(sat_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int when;
        int kind;
        int val;
        int tag;
    } sb_t;

    sb_t sb[$];
    sb_t keep_q[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(input int k);
        case (k)
            0:       return int'(stim_a);
            1:       return int'(count_a);
            2:       return int'(sat_a);
            3:       return int'(stim_b);
            4:       return int'(sat_b);
            default: return int'(count_b);
        endcase
    endfunction

    function automatic string kname(input int k);
        case (k)
            0:       return "stim_a";
            1:       return "count_a";
            2:       return "sat_a";
            3:       return "stim_b";
            4:       return "sat_b";
            default: return "count_b";
        endcase
    endfunction

    // Monitor: compare every entry due this cycle, away from the active edge
    always @(negedge clk) begin
        keep_q.delete();
        foreach (sb[i]) begin
            if (sb[i].when == cyc) begin
                checks++;
                if (actual(sb[i].kind) != sb[i].val) begin
                    errors++;
                    $display("FAIL t%0d %s cyc%0d: got %0d expected %0d", sb[i].tag,
                             kname(sb[i].kind), cyc, actual(sb[i].kind), sb[i].val);
                end
            end else if (sb[i].when < cyc) begin
                checks++;
                errors++;
                $display("FAIL t%0d %s: missed at cyc%0d expected %0d", sb[i].tag,
                         kname(sb[i].kind), sb[i].when, sb[i].val);
            end else begin
                keep_q.push_back(sb[i]);
            end
        end
        sb = keep_q;
    end

    task automatic push(input int k, input int v, input int tag);
        sb_t e;
        e.when = cyc + 1;
        e.kind = k;
        e.val  = v;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic expect3(input int tag, input int s, input int c, input int f);
        push(0, s, tag);
        push(1, c, tag);
        push(2, f, tag);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int tag);
        rst_n    = 1'b0;
        spike_in = 4'h0;
        w_we     = 1'b0;
        enable   = 1'b1;
        expect3(tag, 0, 0, 0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic write_w(input int a, input int d);
        w_we   = 1'b1;
        w_addr = 2'(a);
        w_data = 8'(d);
        step();
        w_we   = 1'b0;
    endtask

    task automatic idle(input int n);
        spike_in = 4'h0;
        for (int i = 0; i < n; i++) step();
    endtask

    int t2_stim[16] = '{16, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    int t4_pat[7]   = '{1, 0, 1, 0, 0, 0, 1};
    int t4_stim[7]  = '{16, 14, 13, 12, 11, 10, 25};
    int t4_cnt[7]   = '{1, 1, 1, 1, 1, 1, 2};

    initial begin
        rst_n = 1'b0; spike_in = 4'hF; enable = 1'b1;
        w_we = 1'b0; w_addr = 2'd0; w_data = 8'd0;

        // Reset held two cycles with all spikes high
        expect3(1, 0, 0, 0); push(3, 0, 1); push(4, 0, 1);
        step();
        expect3(1, 0, 0, 0);
        step();
        rst_n = 1'b1; spike_in = 4'h0;
        expect3(1, 0, 0, 0);
        step();

        // Single held-high event with default weight 16
        spike_in = 4'h1;
        for (int i = 0; i < 20; i++) begin
            push(0, (i < 16) ? t2_stim[i] : 0, 2);
            step();
        end
        spike_in = 4'h0;
        expect3(2, 0, 1, 0);
        step();

        // Coincidence at weight 255, then reset mid-operation clears refractory state
        do_reset(3);
        for (int a = 0; a < 4; a++) write_w(a, 255);
        spike_in = 4'hF;
        expect3(3, 255, 4, 0);
        step();
        rst_n = 1'b0; spike_in = 4'h0;
        expect3(3, 0, 0, 0);
        step();
        rst_n = 1'b1; spike_in = 4'hF;
        expect3(3, 64, 4, 0);
        step();
        spike_in = 4'h0;
        expect3(3, 56, 4, 0);
        step();

        // Refractory: pulses at 0, 2, 6
        do_reset(4);
        for (int i = 0; i < 7; i++) begin
            spike_in = 4'(t4_pat[i]);
            expect3(4, t4_stim[i], t4_cnt[i], 0);
            step();
        end
        idle(1);

        // Enable gating: dropped events still update edge registers; leak continues
        do_reset(7);
        enable = 1'b0; spike_in = 4'h1;
        expect3(7, 0, 0, 0); step();
        enable = 1'b1;
        expect3(7, 0, 0, 0); step();
        spike_in = 4'h0;
        expect3(7, 0, 0, 0); step();
        spike_in = 4'h1;
        expect3(7, 16, 1, 0); step();
        enable = 1'b0; spike_in = 4'h0;
        expect3(7, 14, 1, 0); step();
        spike_in = 4'h1;
        expect3(7, 13, 1, 0); step();
        enable = 1'b1;
        idle(1);

        // Saturation on the REFRAC=0 instance
        do_reset(5);
        for (int a = 0; a < 4; a++) write_w(a, 255);
        for (int i = 0; i < 40; i++) begin
            spike_in = (i % 2 == 0) ? 4'hF : 4'h0;
            push(3, 255, 5);
            if (i == 39) begin
                push(4, 1, 5); push(2, 0, 5); push(1, 28, 5); push(5, 80, 5);
            end
            step();
        end
        idle(9);
        push(4, 1, 5); push(2, 0, 5);
        step();

        // Weight write collision and inhibitory path
        do_reset(6);
        write_w(1, 40);
        spike_in = 4'h2;
        expect3(6, 40, 1, 0); step();
        spike_in = 4'h3; w_we = 1'b1; w_addr = 2'd0; w_data = 8'h90;
        expect3(6, 51, 2, 0); step();
        w_we = 1'b0;
        idle(60);
        push(0, 0, 6);
        write_w(1, 51);
        spike_in = 4'h2;
        push(0, 51, 6); step();
        spike_in = 4'h3;
`ifdef SYN_INHIB_EN
        expect3(6, 29, 4, 0); step();
`else
        expect3(6, 189, 4, 0); step();
`endif
        idle(60);
        push(0, 0, 6);
        write_w(0, 255);
        write_w(1, 10);
        spike_in = 4'h2;
        push(0, 10, 6); step();
        spike_in = 4'h3;
`ifdef SYN_INHIB_EN
        expect3(6, 0, 6, 0); step();
        spike_in = 4'h0;
        push(0, 0, 6); step();
`else
        expect3(6, 255, 6, 0); step();
        spike_in = 4'h0;
        push(0, 231, 6); step();
`endif

        idle(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
